// File: rtl/m_execute_shifter_if.sv
// Execute-stage shifter bus: operation in (control + operand) and result out.
// The master side is the producer/consumer around the shifter; the slave side is the shifter.
interface m_execute_shifter_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       shift;      // {op[2:0], amount[4:0]}
  logic [WIDTH-1:0] data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             illegal;

  modport master (
    output flush, in_valid, shift, data, out_ready,
    input  in_ready, out_valid, result, carry, illegal
  );

  modport slave (
    input  flush, in_valid, shift, data, out_ready,
    output in_ready, out_valid, result, carry, illegal
  );
endinterface

// File: rtl/m_execute_shifter.sv
// Two-stage execute barrel shifter.
// Stage 1 shifts by the coarse amount (0/8/16/24).
// Stage 2 shifts by the fine amount (0..7) and resolves the carry-out.
// Only WIDTH=32 is meaningful because the amount field is 5 bits.
module m_execute_shifter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  m_execute_shifter_if.slave   bus
);

  localparam logic [2:0] OP_SHL = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input logic [4:0] s);
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input logic [4:0] s);
    return (x >> s) | (x << (6'd32 - {1'b0, s}));
  endfunction

  // Pipeline state
  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic [2:0]       s1_fine_q;
  logic [4:0]       s1_amt_q;
  logic [WIDTH-1:0] s1_data_q;
  logic             s1_sign_q;
  logic             s1_cand_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             illegal_q;

  // Handshake
  logic adv1, adv2, in_ready, in_fire;
  assign adv2     = !out_valid_q || bus.out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1 && !bus.flush && rst_n;
  assign in_fire  = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.illegal   = illegal_q;

  // Stage 1 datapath
  logic [2:0]       op_in;
  logic [4:0]       amt_in;
  logic [4:0]       c_sh;
  logic [WIDTH-1:0] coarse_d;
  logic             cand_d;

  assign op_in  = bus.shift[7:5];
  assign amt_in = bus.shift[4:0];
  assign c_sh   = {amt_in[4:3], 3'b000};

  // Coarse shift; cand_d is the last bit pushed out by this stage, used as
  // the carry when the fine amount turns out to be zero.
  always_comb begin
    coarse_d = bus.data;
    cand_d   = 1'b0;
    case (op_in)
      OP_SHL: begin
        coarse_d = bus.data << c_sh;
        if (c_sh != 5'd0) cand_d = bus.data[5'd0 - c_sh];
      end
      OP_SHR: begin
        coarse_d = bus.data >> c_sh;
        if (c_sh != 5'd0) cand_d = bus.data[c_sh - 5'd1];
      end
      OP_ASR: begin
        coarse_d = $signed(bus.data) >>> c_sh;
        if (c_sh != 5'd0) cand_d = bus.data[c_sh - 5'd1];
      end
      OP_ROL:  coarse_d = rotl(bus.data, c_sh);
      OP_ROR:  coarse_d = rotr(bus.data, c_sh);
      default: coarse_d = bus.data;
    endcase
  end

  // Stage 1 payload: only loaded on an accepted input, otherwise held.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_op_q   <= op_in;
      s1_fine_q <= amt_in[2:0];
      s1_amt_q  <= amt_in;
      s1_data_q <= coarse_d;
      s1_sign_q <= bus.data[WIDTH-1];
      s1_cand_q <= cand_d;
    end
  end

  // Stage 2 datapath
  logic [4:0]       f_sh;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             illegal_d;

  assign f_sh = {2'b00, s1_fine_q};

  // Fine shift and final carry selection.
  always_comb begin
    result_d  = s1_data_q;
    carry_d   = s1_cand_q;
    illegal_d = 1'b0;
    case (s1_op_q)
      OP_SHL: begin
        result_d = s1_data_q << f_sh;
        if (f_sh != 5'd0) carry_d = s1_data_q[5'd0 - f_sh];
      end
      OP_SHR: begin
        result_d = s1_data_q >> f_sh;
        if (f_sh != 5'd0) carry_d = s1_data_q[f_sh - 5'd1];
      end
      OP_ASR: begin
        result_d = (s1_data_q >> f_sh) | (s1_sign_q ? ~({WIDTH{1'b1}} >> f_sh) : '0);
        if (f_sh != 5'd0) carry_d = s1_data_q[f_sh - 5'd1];
      end
      OP_ROL: begin
        result_d = rotl(s1_data_q, f_sh);
        carry_d  = result_d[0];
      end
      OP_ROR: begin
        result_d = rotr(s1_data_q, f_sh);
        carry_d  = result_d[WIDTH-1];
      end
      default: begin
        result_d  = s1_data_q;
        carry_d   = 1'b0;
        illegal_d = 1'b1;
      end
    endcase
    // A zero-distance shift never produces a carry, including rotates.
    if (s1_amt_q == 5'd0) carry_d = 1'b0;
  end

  // Valid bits and output register; reset beats flush, flush beats everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (adv1) s1_valid_q <= in_fire;
      if (adv2) out_valid_q <= s1_valid_q;
      if (s1_valid_q && adv2) begin
        result_q  <= result_d;
        carry_q   <= carry_d;
        illegal_q <= illegal_d;
      end
    end
  end

endmodule

// File: tb/tb_m_execute_shifter.sv
// Directed bench for the two-stage execute shifter.
module tb_m_execute_shifter;

  localparam logic [2:0] SHL = 3'd0;
  localparam logic [2:0] SHR = 3'd1;
  localparam logic [2:0] ASR = 3'd2;
  localparam logic [2:0] ROL = 3'd3;
  localparam logic [2:0] ROR = 3'd4;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [31:0] res;
    logic        cy;
    logic        ill;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[15];

  m_execute_shifter_if #(.WIDTH(32)) ifc ();

  m_execute_shifter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] op, input logic [4:0] amt, input logic [31:0] d);
    ifc.in_valid = v;
    ifc.shift    = {op, amt};
    ifc.data     = d;
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{SHL,  5'd4,  32'h8000_000F, 32'h0000_00F0, 1'b0, 1'b0};
    vecs[1]  = '{ASR,  5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2]  = '{ROR,  5'd8,  32'h1234_5678, 32'h7812_3456, 1'b0, 1'b0};
    vecs[3]  = '{SHR,  5'd1,  32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0};
    vecs[4]  = '{SHL,  5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[5]  = '{3'd5, 5'd3,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1};
    vecs[6]  = '{ROL,  5'd31, 32'h0000_0002, 32'h0000_0001, 1'b1, 1'b0};
    vecs[7]  = '{SHL,  5'd9,  32'h0080_0001, 32'h0000_0200, 1'b1, 1'b0};
    vecs[8]  = '{SHL,  5'd8,  32'h0100_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{SHR,  5'd16, 32'h0001_8000, 32'h0000_0001, 1'b1, 1'b0};
    vecs[10] = '{ASR,  5'd12, 32'h8000_1800, 32'hFFF8_0001, 1'b1, 1'b0};
    vecs[11] = '{ROL,  5'd20, 32'h1234_5678, 32'h6781_2345, 1'b1, 1'b0};
    vecs[12] = '{3'd7, 5'd5,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b1};
    vecs[13] = '{ROR,  5'd0,  32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0};
    vecs[14] = '{SHR,  5'd31, 32'hC000_0000, 32'h0000_0001, 1'b1, 1'b0};

    rst_n         = 1'b0;
    ifc.flush     = 1'b0;
    ifc.out_ready = 1'b1;
    drv(1'b0, SHL, 5'd0, 32'h0);

    // Reset state
    nx(); nx();
    #1;
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_result", ifc.result, 32'd0);
    chk("rst_carry", 32'(ifc.carry), 32'd0);
    chk("rst_illegal", 32'(ifc.illegal), 32'd0);
    rst_n = 1'b1;

    // Table vectors: latency 2, then result/carry/illegal
    for (int i = 0; i < 15; i++) begin
      drv(1'b1, vecs[i].op, vecs[i].amt, vecs[i].data);
      #1 chk($sformatf("v%0d_in_ready", i), 32'(ifc.in_ready), 32'd1);
      nx();
      drv(1'b0, SHL, 5'd0, 32'h0);
      chk($sformatf("v%0d_lat1_valid", i), 32'(ifc.out_valid), 32'd0);
      nx();
      chk($sformatf("v%0d_lat2_valid", i), 32'(ifc.out_valid), 32'd1);
      chk($sformatf("v%0d_result", i), ifc.result, vecs[i].res);
      chk($sformatf("v%0d_carry", i), 32'(ifc.carry), 32'(vecs[i].cy));
      chk($sformatf("v%0d_illegal", i), 32'(ifc.illegal), 32'(vecs[i].ill));
    end

    // Stall ordering: A, B, C back to back, consumer stalls cycles 2..5
    drv(1'b1, SHL, 5'd4, 32'h8000_000F);
    nx();
    drv(1'b1, SHR, 5'd1, 32'h0000_0003);
    nx();
    drv(1'b1, ROR, 5'd8, 32'h1234_5678);
    ifc.out_ready = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", k), 32'(ifc.in_ready), 32'd0);
      chk($sformatf("stall%0d_valid", k), 32'(ifc.out_valid), 32'd1);
      chk($sformatf("stall%0d_result", k), ifc.result, 32'h0000_00F0);
      nx();
    end
    ifc.out_ready = 1'b1;
    #1;
    chk("rel_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rel_A_valid", 32'(ifc.out_valid), 32'd1);
    chk("rel_A_result", ifc.result, 32'h0000_00F0);
    nx();
    drv(1'b0, SHL, 5'd0, 32'h0);
    chk("rel_B_valid", 32'(ifc.out_valid), 32'd1);
    chk("rel_B_result", ifc.result, 32'h0000_0001);
    chk("rel_B_carry", 32'(ifc.carry), 32'd1);
    nx();
    chk("rel_C_valid", 32'(ifc.out_valid), 32'd1);
    chk("rel_C_result", ifc.result, 32'h7812_3456);
    nx();
    chk("rel_empty", 32'(ifc.out_valid), 32'd0);

    // Flush with two operations in flight
    ifc.out_ready = 1'b0;
    drv(1'b1, SHL, 5'd1, 32'h0000_0001);
    nx();
    drv(1'b1, SHL, 5'd2, 32'h0000_0001);
    nx();
    ifc.flush = 1'b1;
    drv(1'b1, SHL, 5'd3, 32'h0000_0001);
    #1;
    chk("flush_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("flush_pre_valid", 32'(ifc.out_valid), 32'd1);
    nx();
    ifc.flush     = 1'b0;
    ifc.out_ready = 1'b1;
    drv(1'b1, SHL, 5'd5, 32'h0000_0003);
    chk("flush_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("flush_s1_empty", 32'(dut.s1_valid_q), 32'd0);
    #1 chk("postflush_in_ready", 32'(ifc.in_ready), 32'd1);
    nx();
    drv(1'b0, SHL, 5'd0, 32'h0);
    chk("postflush_lat1", 32'(ifc.out_valid), 32'd0);
    nx();
    chk("postflush_valid", 32'(ifc.out_valid), 32'd1);
    chk("postflush_result", ifc.result, 32'h0000_0060);
    for (int k = 0; k < 3; k++) begin
      nx();
      chk($sformatf("postflush_quiet%0d", k), 32'(ifc.out_valid), 32'd0);
    end

    // Reset while full and stalled
    drv(1'b1, SHL, 5'd4, 32'h8000_000F);
    nx();
    drv(1'b1, SHR, 5'd1, 32'h0000_0003);
    nx();
    drv(1'b0, SHL, 5'd0, 32'h0);
    ifc.out_ready = 1'b0;
    nx();
    chk("prerst_valid", 32'(ifc.out_valid), 32'd1);
    chk("prerst_result", ifc.result, 32'h0000_00F0);
    rst_n = 1'b0;
    #1 chk("inrst_in_ready", 32'(ifc.in_ready), 32'd0);
    nx();
    rst_n         = 1'b1;
    ifc.out_ready = 1'b1;
    chk("midrst_valid", 32'(ifc.out_valid), 32'd0);
    chk("midrst_result", ifc.result, 32'd0);
    chk("midrst_carry", 32'(ifc.carry), 32'd0);
    chk("midrst_illegal", 32'(ifc.illegal), 32'd0);
    for (int k = 0; k < 4; k++) begin
      nx();
      chk($sformatf("postrst_quiet%0d", k), 32'(ifc.out_valid), 32'd0);
    end
    drv(1'b1, ROL, 5'd31, 32'h0000_0002);
    nx();
    drv(1'b0, SHL, 5'd0, 32'h0);
    chk("postrst_lat1", 32'(ifc.out_valid), 32'd0);
    nx();
    chk("postrst_valid", 32'(ifc.out_valid), 32'd1);
    chk("postrst_result", ifc.result, 32'h0000_0001);
    chk("postrst_carry", 32'(ifc.carry), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
